mips_ex_wb_core: RTL and testbench

- Execute and writeback core of the single-issue MIPS lab CPU. Combines the control unit, the 32x32 register file and the ALU.
- Takes the instruction that the fetch stage has registered for EX, reads operands, computes the result and drives GPIO.
- Results are registered into a one-stage writeback pipeline that writes the register file on the following clock edge.

---
 rtl/mips_ex_wb_core.sv | 185 ++++++++++++++++++
 tb/tb_mips_ex_wb_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ex_wb_core.sv
// Execute/writeback core: decode, 32x32 register file with write-through bypass, ALU, GPIO.
// Optional macro MULT_HILO_EN builds mult/multu/mfhi/mflo and the HI/LO registers.
module mips_ex_wb_core #(
  parameter logic [31:0] GPIO_OUT_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ex,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        zero_ex
);
  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_XOR = 4'd2, ALU_NOR = 4'd3,
    ALU_ADD = 4'd4, ALU_SUB = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10,
    ALU_MULT = 4'd11, ALU_MULTU = 4'd12, ALU_LUI = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {SRC_ALU, SRC_HI, SRC_LO, SRC_GPIO} wsrc_t;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = instr_ex[31:26];
  assign rs     = instr_ex[25:21];
  assign rt     = instr_ex[20:16];
  assign rd     = instr_ex[15:11];
  assign shamt  = instr_ex[10:6];
  assign funct  = instr_ex[5:0];
  assign imm    = instr_ex[15:0];

  logic [31:0] regs [32];
  logic        regwrite_wb;
  logic [4:0]  writeaddr_wb;
  logic [31:0] writedata_wb;
  logic [31:0] rs_val, rt_val;

  // A WB write still in flight is forwarded so dependent instructions never stall.
  assign rs_val = (rs == 5'd0) ? 32'h0 :
                  (regwrite_wb && writeaddr_wb == rs) ? writedata_wb : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 :
                  (regwrite_wb && writeaddr_wb == rt) ? writedata_wb : regs[rt];

  alu_op_t     alu_op;
  wsrc_t       wsrc;
  logic        use_imm, sign_ext, reg_write, gpio_write;
  logic [4:0]  waddr;
`ifdef MULT_HILO_EN
  logic        hilo_write;
`endif

  always_comb begin
    alu_op     = ALU_AND;
    wsrc       = SRC_ALU;
    use_imm    = 1'b0;
    sign_ext   = 1'b0;
    reg_write  = 1'b0;
    gpio_write = 1'b0;
    waddr      = rd;
`ifdef MULT_HILO_EN
    hilo_write = 1'b0;
`endif
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
          6'h22, 6'h23: begin alu_op = ALU_SUB;  reg_write = 1'b1; end
          6'h24:        begin alu_op = ALU_AND;  reg_write = 1'b1; end
          6'h25:        begin alu_op = ALU_OR;   reg_write = 1'b1; end
          6'h26:        begin alu_op = ALU_XOR;  reg_write = 1'b1; end
          6'h27:        begin alu_op = ALU_NOR;  reg_write = 1'b1; end
          6'h2A:        begin alu_op = ALU_SLT;  reg_write = 1'b1; end
          6'h2B:        begin alu_op = ALU_SLTU; reg_write = 1'b1; end
          6'h00:        begin alu_op = ALU_SLL;  reg_write = 1'b1; end
          6'h02:        begin alu_op = ALU_SRL;  reg_write = 1'b1; end
          6'h03:        begin alu_op = ALU_SRA;  reg_write = 1'b1; end
`ifdef MULT_HILO_EN
          6'h18:        begin alu_op = ALU_MULT;  hilo_write = 1'b1; end
          6'h19:        begin alu_op = ALU_MULTU; hilo_write = 1'b1; end
          6'h10:        begin wsrc = SRC_HI; reg_write = 1'b1; end
          6'h12:        begin wsrc = SRC_LO; reg_write = 1'b1; end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09: begin alu_op = ALU_ADD;  use_imm = 1'b1; sign_ext = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0A:        begin alu_op = ALU_SLT;  use_imm = 1'b1; sign_ext = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0B:        begin alu_op = ALU_SLTU; use_imm = 1'b1; sign_ext = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0C:        begin alu_op = ALU_AND;  use_imm = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0D:        begin alu_op = ALU_OR;   use_imm = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0E:        begin alu_op = ALU_XOR;  use_imm = 1'b1; reg_write = 1'b1; waddr = rt; end
      6'h0F:        begin alu_op = ALU_LUI;  reg_write = 1'b1; waddr = rt; end
      6'h3E:        gpio_write = 1'b1;
      6'h3F:        begin wsrc = SRC_GPIO; reg_write = 1'b1; waddr = rt; end
      default: ;
    endcase
  end

  logic [31:0] alu_b, alu_lo;
  assign alu_b = !use_imm ? rt_val :
                 sign_ext ? {{16{imm[15]}}, imm} : {16'h0, imm};
`ifdef MULT_HILO_EN
  logic [31:0] alu_hi, hi_reg, lo_reg;
  logic [63:0] prod;
`endif

  always_comb begin
    alu_lo = 32'h0;
`ifdef MULT_HILO_EN
    alu_hi = 32'h0;
    prod   = 64'h0;
`endif
    case (alu_op)
      ALU_AND:  alu_lo = rs_val & alu_b;
      ALU_OR:   alu_lo = rs_val | alu_b;
      ALU_XOR:  alu_lo = rs_val ^ alu_b;
      ALU_NOR:  alu_lo = ~(rs_val | alu_b);
      ALU_ADD:  alu_lo = rs_val + alu_b;
      ALU_SUB:  alu_lo = rs_val - alu_b;
      ALU_SLT:  alu_lo = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_lo = {31'h0, rs_val < alu_b};
      ALU_SLL:  alu_lo = alu_b << shamt;
      ALU_SRL:  alu_lo = alu_b >> shamt;
      ALU_SRA:  alu_lo = $unsigned($signed(alu_b) >>> shamt);
`ifdef MULT_HILO_EN
      ALU_MULT: begin
        // Low 64 bits of the sign-extended product equal the signed product.
        prod = {{32{rs_val[31]}}, rs_val} * {{32{alu_b[31]}}, alu_b};
        {alu_hi, alu_lo} = prod;
      end
      ALU_MULTU: begin
        prod = {32'h0, rs_val} * {32'h0, alu_b};
        {alu_hi, alu_lo} = prod;
      end
`endif
      ALU_LUI:  alu_lo = {imm, 16'h0};
      default:  alu_lo = 32'h0;
    endcase
  end

  assign zero_ex = (alu_lo == 32'h0);

  logic [31:0] wdata;
  always_comb begin
    case (wsrc)
      SRC_GPIO: wdata = gpio_in;
`ifdef MULT_HILO_EN
      SRC_HI:   wdata = hi_reg;
      SRC_LO:   wdata = lo_reg;
`endif
      default:  wdata = alu_lo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regwrite_wb  <= 1'b0;
      writeaddr_wb <= 5'd0;
      writedata_wb <= 32'h0;
      gpio_out     <= GPIO_OUT_RST;
    end else begin
      if (regwrite_wb && writeaddr_wb != 5'd0) regs[writeaddr_wb] <= writedata_wb;
      regwrite_wb  <= reg_write;
      writeaddr_wb <= waddr;
      writedata_wb <= wdata;
      if (gpio_write) gpio_out <= rt_val;
    end
  end

`ifdef MULT_HILO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= 32'h0;
      lo_reg <= 32'h0;
    end else if (hilo_write) begin
      hi_reg <= alu_hi;
      lo_reg <= alu_lo;
    end
  end
`endif

endmodule

// File: tb/tb_mips_ex_wb_core.sv
// Bench for mips_ex_wb_core: directed vector table, reset corner cases and random
// instructions checked against an architectural model; registers are observed via GPIO_OUT.
module tb_mips_ex_wb_core;
`ifdef MULT_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_ex = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] gpio_out;
  logic        zero_ex;

  always #5 clk = ~clk;

  mips_ex_wb_core #(.GPIO_OUT_RST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .instr_ex(instr_ex), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .zero_ex(zero_ex)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo, m_gpio;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] gout(input int rt);
    return i_type(6'h3E, 0, rt, 16'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    m_gpio = 32'h0;
  endtask

  // Architectural effect of one instruction; zv flags whether the ALU result is defined.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] gin, output bit zv, output bit zexp);
    logic [31:0] a, b, res, simm, zimm;
    logic [63:0] p;
    int wr, sh;
    a = m_regs[ins[25:21]];
    b = m_regs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    sh = int'(ins[10:6]);
    res = 32'h0;
    wr = -1;
    zv = 1'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h21: begin res = a + b; wr = ins[15:11]; zv = 1; end
          6'h22, 6'h23: begin res = a - b; wr = ins[15:11]; zv = 1; end
          6'h24: begin res = a & b; wr = ins[15:11]; zv = 1; end
          6'h25: begin res = a | b; wr = ins[15:11]; zv = 1; end
          6'h26: begin res = a ^ b; wr = ins[15:11]; zv = 1; end
          6'h27: begin res = ~(a | b); wr = ins[15:11]; zv = 1; end
          6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = ins[15:11]; zv = 1; end
          6'h2B: begin res = (a < b) ? 32'd1 : 32'd0; wr = ins[15:11]; zv = 1; end
          6'h00: begin res = b << sh; wr = ins[15:11]; zv = 1; end
          6'h02: begin res = b >> sh; wr = ins[15:11]; zv = 1; end
          6'h03: begin res = $signed(b) >>> sh; wr = ins[15:11]; zv = 1; end
          6'h18: if (HILO) begin
            p = longint'($signed(a)) * longint'($signed(b));
            m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; zv = 1;
          end
          6'h19: if (HILO) begin
            p = longint'({32'h0, a}) * longint'({32'h0, b});
            m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; zv = 1;
          end
          6'h10: if (HILO) begin res = m_hi; wr = ins[15:11]; end
          6'h12: if (HILO) begin res = m_lo; wr = ins[15:11]; end
          default: ;
        endcase
      end
      6'h08, 6'h09: begin res = a + simm; wr = ins[20:16]; zv = 1; end
      6'h0A: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; wr = ins[20:16]; zv = 1; end
      6'h0B: begin res = (a < simm) ? 32'd1 : 32'd0; wr = ins[20:16]; zv = 1; end
      6'h0C: begin res = a & zimm; wr = ins[20:16]; zv = 1; end
      6'h0D: begin res = a | zimm; wr = ins[20:16]; zv = 1; end
      6'h0E: begin res = a ^ zimm; wr = ins[20:16]; zv = 1; end
      6'h0F: begin res = {ins[15:0], 16'h0}; wr = ins[20:16]; zv = 1; end
      6'h3E: m_gpio = b;
      6'h3F: begin res = gin; wr = ins[20:16]; end
      default: ;
    endcase
    zexp = (res == 32'h0);
    if (wr > 0) m_regs[wr] = res;
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] gin, input string tag);
    bit zv, ze;
    @(negedge clk);
    instr_ex = ins;
    gpio_in = gin;
    model_exec(ins, gin, zv, ze);
    #1;
    if (zv) check({tag, " zero_ex"}, {31'h0, zero_ex}, {31'h0, ze});
    @(posedge clk);
    #1;
    check({tag, " gpio_out"}, gpio_out, m_gpio);
    n_txn++;
    $display("txn %0d %s instr=%08h gpio_out=%08h zero_ex=%0b", n_txn, tag, ins, gpio_out, zero_ex);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] gin;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] ins, input logic [31:0] gin, input bit chk, input logic [31:0] exp, input string name);
    vec_t v;
    v.instr = ins; v.gin = gin; v.chk = chk; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rfn [17];
    logic [5:0] iop [8];
    logic [5:0] bad_op [5];
    logic [15:0] imm;
    int kind;

    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
            6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    bad_op = '{6'h3B, 6'h02, 6'h04, 6'h23, 6'h2B};

    add(i_type(6'h08, 0, 1, 16'h0005), 0, 0, 0, "addi r1");
    add(i_type(6'h08, 1, 2, 16'hFFFD), 0, 0, 0, "addi r2 bypass");
    add(gout(1), 0, 1, 32'd5, "read r1");
    add(gout(2), 0, 1, 32'd2, "read r2");
    add(i_type(6'h08, 0, 1, 16'hFFFE), 0, 0, 0, "addi r1 -2");
    add(i_type(6'h08, 0, 2, 16'h0003), 0, 0, 0, "addi r2 3");
    add(r_type(1, 2, 0, 0, 6'h18), 0, 0, 0, "mult");
    add(r_type(0, 0, 3, 0, 6'h10), 0, 0, 0, "mfhi r3");
    add(r_type(0, 0, 4, 0, 6'h12), 0, 0, 0, "mflo r4");
    add(gout(3), 0, 1, HILO ? 32'hFFFF_FFFF : 32'h0, "read mult hi");
    add(gout(4), 0, 1, HILO ? 32'hFFFF_FFFA : 32'h0, "read mult lo");
    add(r_type(1, 2, 0, 0, 6'h19), 0, 0, 0, "multu");
    add(r_type(0, 0, 3, 0, 6'h10), 0, 0, 0, "mfhi r3");
    add(r_type(0, 0, 4, 0, 6'h12), 0, 0, 0, "mflo r4");
    add(gout(3), 0, 1, HILO ? 32'h0000_0002 : 32'h0, "read multu hi");
    add(gout(4), 0, 1, HILO ? 32'hFFFF_FFFA : 32'h0, "read multu lo");
    add(i_type(6'h0F, 0, 5, 16'h8000), 0, 0, 0, "lui r5");
    add(r_type(0, 5, 6, 4, 6'h03), 0, 0, 0, "sra r6");
    add(r_type(0, 5, 7, 4, 6'h02), 0, 0, 0, "srl r7");
    add(gout(6), 0, 1, 32'hF800_0000, "read sra");
    add(gout(7), 0, 1, 32'h0800_0000, "read srl");
    add(r_type(5, 0, 8, 0, 6'h2A), 0, 0, 0, "slt r8");
    add(gout(8), 0, 1, 32'd1, "read slt");
    add(r_type(5, 0, 8, 0, 6'h2B), 0, 0, 0, "sltu r8");
    add(gout(8), 0, 1, 32'd0, "read sltu");
    add(i_type(6'h0D, 0, 9, 16'hFFFF), 0, 0, 0, "ori r9");
    add(gout(9), 0, 1, 32'h0000_FFFF, "read ori");
    add(i_type(6'h08, 0, 9, 16'hFFFF), 0, 0, 0, "addi r9");
    add(gout(9), 0, 1, 32'hFFFF_FFFF, "read addi sext");
    add(i_type(6'h08, 0, 0, 16'h0007), 0, 0, 0, "addi r0");
    add(gout(0), 0, 1, 32'h0, "read r0");
    add(r_type(0, 1, 12, 0, 6'h22), 0, 0, 0, "sub r12");
    add(gout(12), 0, 1, 32'd2, "read sub");
    add(i_type(6'h3F, 0, 10, 16'h0), 32'h1234_5678, 0, 0, "gpio_in r10");
    add(gout(10), 0, 1, 32'h1234_5678, "gpio_out r10");
    add(i_type(6'h3B, 0, 10, 16'h00FF), 32'hDEAD_BEEF, 0, 0, "unknown op");
    add(r_type(1, 2, 10, 0, 6'h3F), 0, 0, 0, "unknown funct");
    add(gout(10), 0, 1, 32'h1234_5678, "r10 after nops");

    // Reset: gpio_out must hold its reset value for the whole reset window.
    model_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset gpio_out", gpio_out, 32'h0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      run(tbl[i].instr, tbl[i].gin, tbl[i].name);
      if (tbl[i].chk) check({tbl[i].name, " value"}, gpio_out, tbl[i].exp);
    end

    // Asynchronous reset while the WB write of addi r11 is pending.
    @(negedge clk);
    instr_ex = i_type(6'h08, 0, 11, 16'h0009);
    @(posedge clk);
    #1;
    instr_ex = 32'h0;
    rst = 1'b1;
    #1;
    check("async reset gpio_out", gpio_out, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(gout(11), 0, "read r11 after reset");
    check("r11 aborted write", gpio_out, 32'h0);
    run(gout(1), 0, "read r1 after reset");
    check("r1 cleared", gpio_out, 32'h0);

    // Random instruction mix over r0..r7 to stress bypass and dependencies.
    for (int n = 0; n < 400; n++) begin
      imm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) imm = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
      kind = $urandom_range(0, 9);
      if (kind <= 3)
        run(r_type($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 31), rfn[$urandom_range(0, 16)]), 0, "rand r");
      else if (kind <= 6)
        run(i_type(iop[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7), imm), 0, "rand i");
      else if (kind == 7)
        run(i_type(6'h3F, 0, $urandom_range(0, 7), imm), $urandom, "rand gpio_in");
      else if (kind == 8)
        run(gout($urandom_range(0, 7)), 0, "rand gpio_out");
      else
        run(i_type(bad_op[$urandom_range(0, 4)], $urandom_range(0, 7), $urandom_range(0, 7), imm), $urandom, "rand nop");
    end
    for (int r = 0; r < 8; r++) run(gout(r), 0, "final readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
